// File: rtl/gfx_pkg.sv
// gfx_pkg: shared types for the pixel read-modify-write block.
//   rmw_op_t    - raster op applied to the selected strip field
//   rmw_state_t - controller state encoding (IDLE/READ/MERGE/WRITE)
package gfx_pkg;

  typedef enum logic [1:0] {
    COPY = 2'd0,
    AND  = 2'd1,
    OR   = 2'd2,
    XOR  = 2'd3
  } rmw_op_t;

  // Plain vector plus named constants keeps the encoding visible to
  // older tools and waveform viewers.
  typedef logic [1:0] rmw_state_t;

  localparam rmw_state_t ST_IDLE  = 2'd0;
  localparam rmw_state_t ST_READ  = 2'd1;
  localparam rmw_state_t ST_MERGE = 2'd2;
  localparam rmw_state_t ST_WRITE = 2'd3;

endpackage

// File: rtl/gfx_strip_merge.sv
// gfx_strip_merge: combinational field merge for one strip.
//   strip_i  - strip as read from memory (or cache)
//   color_i  - right-justified colour; bit 0 lands on strip bit mb_i
//   mb_i     - lowest bit of the pixel field
//   me_i     - highest bit of the pixel mask
//   ce_i     - highest bit actually written with colour bits
//   op_i     - raster op
//   strip_o  - merged strip; only bits ce_i..mb_i can differ from strip_i
module gfx_strip_merge
  import gfx_pkg::*;
#(
  parameter int SW = 256,
  parameter int BN = $clog2(SW) - 1
) (
  input  logic [SW-1:0] strip_i,
  input  logic [31:0]   color_i,
  input  logic [BN:0]   mb_i,
  input  logic [BN:0]   me_i,
  input  logic [BN:0]   ce_i,
  input  rmw_op_t       op_i,
  output logic [SW-1:0] strip_o
);

  localparam int         BW  = BN + 1;
  localparam logic [BN:0] TOP = BW'(SW - 1);

  logic [SW-1:0] ones_s;
  logic [SW-1:0] mask_s;
  logic [SW-1:0] col_s;
  logic [SW-1:0] op_s;

  // Build the field mask, align the colour and apply the raster op
  always_comb begin
    ones_s = '1;
    // Field is [ce:mb]; clipping at me too keeps me..ce+1 untouched even
    // if a caller ever hands in ce above me.
    mask_s = (ones_s << mb_i) & (ones_s >> (TOP - ce_i)) & (ones_s >> (TOP - me_i));
    // Colour bits beyond bit 31 of a wide field read as zero.
    col_s        = '0;
    col_s[31:0]  = color_i;
    col_s        = col_s << mb_i;
    case (op_i)
      COPY:    op_s = col_s;
      AND:     op_s = strip_i & col_s;
      OR:      op_s = strip_i | col_s;
      XOR:     op_s = strip_i ^ col_s;
      default: op_s = col_s;
    endcase
    strip_o = (strip_i & ~mask_s) | (op_s & mask_s);
  end

endmodule

// File: rtl/gfx_pixel_rmw.sv
// gfx_pixel_rmw: read-modify-write of one pixel field inside a memory strip.
// Optional feature macro: GFX_STRIP_CACHE_EN (one-entry write-through strip
// cache that skips the READ cycle on an address hit).
//   clk, rst           - clock and synchronous active-high reset
//   req_i / rdy_o      - request handshake; rdy_o is high only when idle
//   address_i          - strip byte address
//   mb_i, me_i, ce_i   - mask begin, mask end, colour-bits end
//   color_i, op_i      - right-justified colour and raster op
//   inv_i              - strip cache invalidate
//   m_cyc_o, m_we_o    - memory cycle and write enable
//   m_adr_o, m_dat_o   - memory address and write data
//   m_ack_i, m_dat_i   - memory acknowledge and read data
//   done_o, err_o      - completion pulse and rejected-request flag
module gfx_pixel_rmw
  import gfx_pkg::*;
#(
  parameter int SW = 256,
  parameter int BN = $clog2(SW) - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  output logic          rdy_o,
  input  logic [31:0]   address_i,
  input  logic [BN:0]   mb_i,
  input  logic [BN:0]   me_i,
  input  logic [BN:0]   ce_i,
  input  logic [31:0]   color_i,
  input  logic [1:0]    op_i,
  input  logic          inv_i,
  output logic          m_cyc_o,
  output logic          m_we_o,
  output logic [31:0]   m_adr_o,
  output logic [SW-1:0] m_dat_o,
  input  logic          m_ack_i,
  input  logic [SW-1:0] m_dat_i,
  output logic          done_o,
  output logic          err_o
);

  rmw_state_t    state_q;
  rmw_state_t    state_d;
  logic          rdy_q;
  logic          err_pend_q;
  logic          done_q;
  logic          err_q;
  logic          m_cyc_q;
  logic          m_we_q;
  logic [31:0]   m_adr_q;
  logic [SW-1:0] m_dat_q;
  logic [31:0]   adr_q;
  logic [31:0]   color_q;
  logic [BN:0]   mb_q;
  logic [BN:0]   me_q;
  logic [BN:0]   ce_q;
  rmw_op_t       op_q;
  logic [SW-1:0] strip_q;
  logic [SW-1:0] merged_s;
  logic          accept_s;
  logic          bad_s;
  logic          hit_s;
  logic [SW-1:0] hit_dat_s;

  assign rdy_o   = rdy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign m_cyc_o = m_cyc_q;
  assign m_we_o  = m_we_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;

`ifdef GFX_STRIP_CACHE_EN
  logic [31:0]   cache_adr_q;
  logic [SW-1:0] cache_dat_q;
  logic          cache_vld_q;

  // Hit test against the raw request; an invalidate in the accept cycle wins
  always_comb begin
    hit_s     = cache_vld_q && !inv_i && (cache_adr_q == address_i);
    hit_dat_s = cache_dat_q;
  end

  // Write-through fill on every write ack; invalidate beats a same-cycle fill
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_adr_q <= 32'd0;
      cache_dat_q <= '0;
    end else if (inv_i) begin
      cache_vld_q <= 1'b0;
    end else if ((state_q == ST_WRITE) && m_ack_i) begin
      cache_vld_q <= 1'b1;
      cache_adr_q <= adr_q;
      cache_dat_q <= m_dat_q;
    end else begin
      cache_vld_q <= cache_vld_q;
    end
  end
`else
  logic unused_inv_s;

  // No cache: never hit, invalidate has nothing to act on
  always_comb begin
    hit_s        = 1'b0;
    hit_dat_s    = '0;
    unused_inv_s = inv_i;
  end
`endif

  // Request qualification from the raw inputs at the accept edge
  always_comb begin
    accept_s = req_i && rdy_q;
    bad_s    = (me_i < mb_i) || (ce_i > me_i);
  end

  gfx_strip_merge #(
    .SW (SW),
    .BN (BN)
  ) u_merge (
    .strip_i (strip_q),
    .color_i (color_q),
    .mb_i    (mb_q),
    .me_i    (me_q),
    .ce_i    (ce_q),
    .op_i    (op_q),
    .strip_o (merged_s)
  );

  // Controller next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !bad_s) begin
          state_d = hit_s ? ST_MERGE : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (m_ack_i) begin
          state_d = ST_MERGE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: begin
        if (m_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, registered bus outputs and completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b1;
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      m_cyc_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_adr_q    <= 32'd0;
      m_dat_q    <= '0;
      adr_q      <= 32'd0;
      color_q    <= 32'd0;
      mb_q       <= '0;
      me_q       <= '0;
      ce_q       <= '0;
      op_q       <= COPY;
      strip_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A rejected request holds rdy low for one cycle so the
          // error pulse and rdy rise together.
          if (err_pend_q) begin
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            rdy_q      <= 1'b1;
            err_pend_q <= 1'b0;
          end else if (accept_s) begin
            adr_q   <= address_i;
            color_q <= color_i;
            mb_q    <= mb_i;
            me_q    <= me_i;
            ce_q    <= ce_i;
            op_q    <= rmw_op_t'(op_i);
            rdy_q   <= 1'b0;
            if (bad_s) begin
              err_pend_q <= 1'b1;
            end else if (hit_s) begin
              strip_q <= hit_dat_s;
            end else begin
              m_cyc_q <= 1'b1;
              m_we_q  <= 1'b0;
              m_adr_q <= address_i;
            end
          end
        end
        ST_READ: begin
          if (m_ack_i) begin
            strip_q <= m_dat_i;
            m_cyc_q <= 1'b0;
          end
        end
        ST_MERGE: begin
          m_cyc_q <= 1'b1;
          m_we_q  <= 1'b1;
          m_adr_q <= adr_q;
          m_dat_q <= merged_s;
        end
        ST_WRITE: begin
          if (m_ack_i) begin
            m_cyc_q <= 1'b0;
            m_we_q  <= 1'b0;
            done_q  <= 1'b1;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          m_cyc_q <= 1'b0;
          m_we_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_pixel_rmw.sv
// tb_gfx_pixel_rmw: directed plus randomized checks of gfx_pixel_rmw against
// a bit-level reference model and a registered-ack memory model.
module tb_gfx_pixel_rmw;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_i = 1'b0;
  logic         rdy_o;
  logic [31:0]  address_i = 32'd0;
  logic [7:0]   mb_i = 8'd0;
  logic [7:0]   me_i = 8'd0;
  logic [7:0]   ce_i = 8'd0;
  logic [31:0]  color_i = 32'd0;
  logic [1:0]   op_i = 2'd0;
  logic         inv_i = 1'b0;
  logic         m_cyc_o;
  logic         m_we_o;
  logic [31:0]  m_adr_o;
  logic [255:0] m_dat_o;
  logic         m_ack_i;
  logic [255:0] m_dat_i;
  logic         done_o;
  logic         err_o;

  gfx_pixel_rmw #(.SW(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .rdy_o     (rdy_o),
    .address_i (address_i),
    .mb_i      (mb_i),
    .me_i      (me_i),
    .ce_i      (ce_i),
    .color_i   (color_i),
    .op_i      (op_i),
    .inv_i     (inv_i),
    .m_cyc_o   (m_cyc_o),
    .m_we_o    (m_we_o),
    .m_adr_o   (m_adr_o),
    .m_dat_o   (m_dat_o),
    .m_ack_i   (m_ack_i),
    .m_dat_i   (m_dat_i),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // memory model: strips indexed by address bits 15:12, written only by the bench
  logic [255:0] mem [16];
  int   rd_wait = 0;
  int   wr_wait = 0;
  bit   wr_hold = 1'b0;
  logic ack_r = 1'b0;
  logic [255:0] rdat_r = '0;
  int   wcnt = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   cyc_cnt = 0;
  int   adr_bad = 0;
  bit   in_cyc = 1'b0;
  logic [31:0]  cyc_adr = 32'd0;
  logic [31:0]  last_wr_adr = 32'd0;
  logic [255:0] last_wr_dat = '0;

  // cache expectation (stays invalid when the cache is not built)
  bit          c_vld = 1'b0;
  logic [31:0] c_adr = 32'd0;

  assign m_ack_i = ack_r;
  assign m_dat_i = rdat_r;

  // registered-ack slave: ack rises (wait+1) edges after cyc is first seen
  always @(posedge clk) begin
    ack_r <= 1'b0;
    if (m_cyc_o) begin
      cyc_cnt <= cyc_cnt + 1;
      in_cyc  <= 1'b1;
      if (!in_cyc) cyc_adr <= m_adr_o;
      else if (m_adr_o !== cyc_adr) adr_bad <= adr_bad + 1;
      if (!ack_r) begin
        if (m_we_o && wr_hold) begin
          wcnt <= 0;
        end else if (wcnt >= (m_we_o ? wr_wait : rd_wait)) begin
          ack_r <= 1'b1;
          wcnt  <= 0;
          if (m_we_o) begin
            wr_cnt      <= wr_cnt + 1;
            last_wr_adr <= m_adr_o;
            last_wr_dat <= m_dat_o;
          end else begin
            rd_cnt <= rd_cnt + 1;
            rdat_r <= mem[m_adr_o[15:12]];
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end else begin
      wcnt   <= 0;
      in_cyc <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // field [ce:mb] gets op(strip bit, colour bit i-mb); colour bits past 31 are 0
  function automatic logic [255:0] ref_merge(input logic [255:0] s, input int mb, input int ce,
                                             input logic [31:0] c, input int op);
    logic [255:0] r;
    r = s;
    for (int i = mb; i <= ce; i++) begin
      logic cb;
      cb = (i - mb < 32) ? c[i-mb] : 1'b0;
      case (op)
        0:       r[i] = cb;
        1:       r[i] = s[i] & cb;
        2:       r[i] = s[i] | cb;
        default: r[i] = s[i] ^ cb;
      endcase
    end
    return r;
  endfunction

  task automatic run_txn(input string tag, input logic [31:0] adr, input int mb, input int me,
                         input int ce, input logic [31:0] col, input int op,
                         input int nr, input int nw, input int hold);
    int slot, lat, exp_lat, rd0, wr0, cyc0;
    bit seen, prev_rdy, exp_err, exp_hit;
    logic [255:0] exp_d;
    slot    = int'(adr[15:12]);
    exp_err = (me < mb) || (ce > me);
    exp_hit = c_vld && (c_adr == adr) && !exp_err;
    exp_d   = ref_merge(mem[slot], mb, ce, col, op);
    exp_lat = exp_err ? 1 : (exp_hit ? 3 + nw : 5 + nr + nw);
    rd0 = rd_cnt; wr0 = wr_cnt; cyc0 = cyc_cnt;
    @(negedge clk);
    rd_wait = nr; wr_wait = nw;
    address_i = adr; mb_i = 8'(mb); me_i = 8'(me); ce_i = 8'(ce);
    color_i = col; op_i = 2'(op); req_i = 1'b1;
    chk({tag, " rdy_before"}, rdy_o, 1'b1);
    @(posedge clk);
    lat = 0; seen = 1'b0; prev_rdy = 1'b1;
    while (!seen && lat < 200) begin
      @(negedge clk);
      if (lat >= hold) req_i = 1'b0;
      if (done_o) begin
        seen = 1'b1;
      end else begin
        prev_rdy = rdy_o;
        @(posedge clk);
        lat++;
      end
    end
    req_i = 1'b0;
    chk({tag, " done_seen"}, seen, 1'b1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " err"}, err_o, exp_err);
    chk({tag, " rdy_with_done"}, rdy_o, 1'b1);
    chk({tag, " rdy_low_before"}, prev_rdy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_pulse"}, done_o, 1'b0);
    chk({tag, " rdy_after"}, rdy_o, 1'b1);
    if (exp_err) begin
      chk({tag, " no_cyc"}, cyc_cnt - cyc0, 0);
    end else begin
      chk({tag, " reads"}, rd_cnt - rd0, exp_hit ? 0 : 1);
      chk({tag, " writes"}, wr_cnt - wr0, 1);
      chk({tag, " wr_adr"}, last_wr_adr, adr);
      chk({tag, " wr_dat"}, last_wr_dat, exp_d);
      mem[slot] = exp_d;
`ifdef GFX_STRIP_CACHE_EN
      c_vld = 1'b1;
      c_adr = adr;
`endif
    end
  endtask

  initial begin
    logic [255:0] e;
    logic [255:0] rv;
    int wr0, pulses, mb, me, ce, slot;
    bit reached;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rdy", rdy_o, 1'b1);
    chk("rst cyc", m_cyc_o, 1'b0);
    chk("rst we", m_we_o, 1'b0);
    chk("rst done", done_o, 1'b0);
    chk("rst err", err_o, 1'b0);
    chk("rst adr", m_adr_o, 32'd0);
    chk("rst dat", m_dat_o, 256'd0);
    rst = 1'b0;

    // COPY of 0xABCD into bits 31:16 of an all-ones strip
    mem[1] = '1;
    e = '1;
    e[31:16] = 16'hABCD;
    run_txn("copy", 32'h0000_1000, 16, 31, 31, 32'h0000_ABCD, 0, 0, 0, 0);
    chk("copy const", last_wr_dat, e);

    // XOR of 30 ones into a zero strip, bits 31:30 untouched
    mem[5] = '0;
    run_txn("xor", 32'h0000_5000, 0, 31, 29, 32'h3FFF_FFFF, 3, 0, 0, 0);
    chk("xor const", last_wr_dat, 256'h3FFF_FFFF);

    // rejected requests
    run_txn("bad_me_lt_mb", 32'h0000_6000, 40, 32, 32, 32'h1, 0, 0, 0, 0);
    run_txn("bad_ce_gt_me", 32'h0000_6000, 0, 10, 11, 32'h1, 0, 0, 0, 0);

    // request held high through a slow READ is taken once
    mem[7] = 256'h1234_5678_9ABC_DEF0;
    run_txn("hold", 32'h0000_7000, 4, 20, 11, 32'h0000_00FF, 2, 3, 0, 3);

    // wait states on both cycles, AND, top-of-strip field
    mem[8] = '1;
    run_txn("wait_and", 32'h0000_8000, 224, 255, 255, 32'h0F0F_0F0F, 1, 2, 3, 0);

    // wide field: colour bits beyond 31 read as zero
    mem[9] = '1;
    run_txn("wide", 32'h0000_9000, 0, 255, 255, 32'hFFFF_FFFF, 0, 1, 1, 0);

    // back-to-back to one address, invalidate, then again
    mem[2] = 256'hA5A5;
    run_txn("c1", 32'h0000_2000, 8, 15, 15, 32'h0000_003C, 0, 0, 0, 0);
    run_txn("c2", 32'h0000_2000, 0, 7, 7, 32'h0000_00C3, 3, 1, 1, 0);
    @(negedge clk);
    inv_i = 1'b1;
    @(negedge clk);
    inv_i = 1'b0;
    c_vld = 1'b0;
    run_txn("c3", 32'h0000_2000, 16, 23, 23, 32'h0000_0055, 2, 0, 0, 0);

    // reset while a write is stalled
    wr0 = wr_cnt;
    wr_hold = 1'b1;
    @(negedge clk);
    rd_wait = 0;
    address_i = 32'h0000_3000; mb_i = 8'd0; me_i = 8'd7; ce_i = 8'd7;
    color_i = 32'h0000_0011; op_i = 2'd0; req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 60 && !reached; k++) begin
      if (m_cyc_o && m_we_o) reached = 1'b1;
      else @(negedge clk);
    end
    chk("mid reach_write", reached, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid cyc", m_cyc_o, 1'b0);
    chk("mid we", m_we_o, 1'b0);
    chk("mid rdy", rdy_o, 1'b1);
    chk("mid done", done_o, 1'b0);
    chk("mid adr", m_adr_o, 32'd0);
    chk("mid dat", m_dat_o, 256'd0);
    wr_hold = 1'b0;
    c_vld = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    chk("mid no_done", pulses, 0);
    chk("mid no_write", wr_cnt - wr0, 0);
    run_txn("after_rst", 32'h0000_3000, 0, 7, 7, 32'h0000_0022, 0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 14; n++) begin
      slot = $urandom_range(1, 15);
      if (!(c_vld && c_adr == (32'(slot) << 12))) begin
        for (int w = 0; w < 8; w++) rv[w*32 +: 32] = $urandom;
        mem[slot] = rv;
      end
      if (n % 7 == 6) begin
        me = $urandom_range(0, 254);
        mb = $urandom_range(me + 1, 255);
        ce = me;
      end else begin
        mb = $urandom_range(0, 230);
        ce = mb + $urandom_range(0, 25);
        me = $urandom_range(ce, 255);
      end
      run_txn("rand", 32'(slot) << 12, mb, me, ce, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    chk("adr_stable", adr_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gfx_pixel_rmw.md
GFX_PIXEL_RMW -- requirements
Module: gfx_pixel_rmw

Interface
REQ-001 SHALL have parameter SW, default 256; strip width in bits (32, 64, 128 or 256).
REQ-002 SHALL have parameter BN, default $clog2(SW)-1; MSB index of bit-position ports.
REQ-003 SHALL have port clk, input, 1; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset, synchronous and active-high.
REQ-005 SHALL have port req_i, input, 1; pixel write request valid.
REQ-006 SHALL have port rdy_o, output, 1; block can accept a request.
REQ-007 SHALL have port address_i, input, 32; strip byte address.
REQ-008 SHALL have ports mb_i, me_i and ce_i, input, BN+1 each; pixel mask begin, mask end and colour-bits end.
REQ-009 SHALL have port color_i, input, 32; pixel colour, right-justified.
REQ-010 SHALL have port op_i, input, 2; raster op (COPY, AND, OR, XOR).
REQ-011 SHALL have port inv_i, input, 1; strip cache invalidate.
REQ-012 SHALL have ports m_cyc_o and m_we_o, output, 1 each; memory cycle active and write enable.
REQ-013 SHALL have port m_adr_o, output, 32; memory address.
REQ-014 SHALL have port m_dat_o, output, SW; write data.
REQ-015 SHALL have ports m_ack_i, input, 1 and m_dat_i, input, SW; memory acknowledge and read data.
REQ-016 SHALL have ports done_o and err_o, output, 1 each; one-cycle completion pulse and rejected-request flag.

Function
REQ-017 SHALL implement states IDLE, READ, MERGE, WRITE; rdy_o = 1 only in IDLE.
REQ-018 SHALL capture all request inputs when req_i && rdy_o, and ignore req_i in every other state.
REQ-019 SHALL, when a captured request has me_i < mb_i or ce_i > me_i, issue no memory cycle, stay in IDLE, and pulse done_o and err_o together on the next cycle.
REQ-020 SHALL, for a valid request, move IDLE->READ; READ drives m_cyc_o=1, m_we_o=0, m_adr_o=address until m_ack_i, then latches m_dat_i and moves ->MERGE.
REQ-021 SHALL spend exactly one cycle in MERGE; bits ce..mb become op(strip[ce:mb], color[ce-mb:0]); bits me..ce+1 and all bits outside mb..me are unchanged.
REQ-022 SHALL, in WRITE, drive m_cyc_o=1, m_we_o=1, m_dat_o=merged strip until m_ack_i, then move ->IDLE and pulse done_o on the following cycle.
REQ-023 SHALL have latency, with cache off, memory acks after Nr and Nw wait cycles: done_o high exactly Nr+Nw+5 cycles after the accept edge; rdy_o rises in the same cycle as done_o.
REQ-024 SHALL keep m_adr_o stable and m_cyc_o high throughout a memory cycle; m_ack_i outside READ/WRITE is ignored.

Reset
REQ-025 SHALL, on any rising edge with rst=1, including mid-operation, go to IDLE with rdy_o=1 and m_cyc_o, m_we_o, done_o, err_o = 0, m_adr_o = 0, m_dat_o = 0, cache invalid; an in-flight memory cycle is abandoned.

Configuration
REQ-026 SHALL, with GFX_STRIP_CACHE_EN defined, keep a one-entry write-through strip cache (address, data, valid) updated on every WRITE ack.
REQ-027 SHALL, on a cache hit (valid and address equal), go IDLE->MERGE without a READ cycle; inv_i or rst clears valid, and inv_i takes priority over a same-cycle WRITE ack fill.
REQ-028 SHALL, without GFX_STRIP_CACHE_EN, always perform READ, ignore inv_i, and contain no cache storage.

Structure
REQ-029 SHALL take the raster op typedef (rmw_op_t: COPY=0, AND=1, OR=2, XOR=3) and the state typedef from gfx_pkg.
REQ-030 SHALL put the combinational mask/op merge in one sub-module, gfx_strip_merge, instantiated once.

Verification
REQ-031 SHALL check: addr 0x1000, mb=16, me=31, ce=31, color 0xABCD, COPY, memory strip all ones, acks 0-wait -> write data all ones except bits 31:16 = 0xABCD; done_o 5 cycles after accept.
REQ-032 SHALL check: mb=0, me=31, ce=29, color 0x3FFFFFFF, XOR, strip 0 -> bits 29:0 = 0x3FFFFFFF; bits 31:30 unchanged = 0.
REQ-033 SHALL check: mb=40, me=32 -> no m_cyc_o; done_o and err_o high one cycle after accept.
REQ-034 SHALL check: rst asserted while in WRITE with ack withheld -> next cycle m_cyc_o=0, rdy_o=1, no done_o.
REQ-035 SHALL check, with GFX_STRIP_CACHE_EN: two back-to-back writes to 0x2000 -> second has no read cycle; after inv_i, the third write reads again.
REQ-036 SHALL check: req_i held high in READ with 3 ack wait states -> exactly one transaction performed.
